hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller that drives the ID/EX bubble control (stall_pipe) and the front-end hold signals. It detects load-use hazards between the instruction in decode (stage 2) and a load in execute (stage 3). It also freezes the whole pipe while data memory is not ready, and drains and parks the pipe after a halt reaches execute. It sits beside the ID/EX register and consumes that register's stage-3 outputs.

---
 rtl/hazard_stall_ctrl_if.sv | 48 ++++
 rtl/hazard_stall_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundle of the signals exchanged between the pipeline datapath and the
// hazard/stall controller.
//   master : pipeline side. It drives the stage-2/3/4 status and receives
//            the stall, hold, freeze and status outputs.
//   slave  : controller side. It receives the status and drives the outputs.
// Stage-2 inputs  : r1_addr, r2_addr, r1_used, r2_used
// Stage-3 inputs  : waddr_s3, rw_s3 (active-low write), sel_mem_s3, halt_s3
// Stage-4 inputs  : mem_req_s4, mem_ready
// Outputs         : stall_pipe, hold_s1, freeze_all, halted, mem_timeout,
//                   stall_count
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_LEFT = 4,
    parameter int CNT_BITS      = 16
);
    logic [REG_ADDR_LEFT:0] r1_addr;
    logic [REG_ADDR_LEFT:0] r2_addr;
    logic                   r1_used;
    logic                   r2_used;
    logic [REG_ADDR_LEFT:0] waddr_s3;
    logic                   rw_s3;
    logic                   sel_mem_s3;
    logic                   halt_s3;
    logic                   mem_req_s4;
    logic                   mem_ready;
    logic                   stall_pipe;
    logic                   hold_s1;
    logic                   freeze_all;
    logic                   halted;
    logic                   mem_timeout;
    logic [CNT_BITS-1:0]    stall_count;

    modport master (
        output r1_addr, r2_addr, r1_used, r2_used,
        output waddr_s3, rw_s3, sel_mem_s3, halt_s3,
        output mem_req_s4, mem_ready,
        input  stall_pipe, hold_s1, freeze_all, halted, mem_timeout, stall_count
    );

    modport slave (
        input  r1_addr, r2_addr, r1_used, r2_used,
        input  waddr_s3, rw_s3, sel_mem_s3, halt_s3,
        input  mem_req_s4, mem_ready,
        output stall_pipe, hold_s1, freeze_all, halted, mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// This module is the pipeline hazard and stall controller. It sits beside the
// ID/EX register and performs four jobs:
//   - It inserts a one-cycle bubble on a load-use hazard between decode and
//     execute.
//   - It freezes the whole pipe while data memory is not ready. If the wait
//     runs past MAX_WAIT cycles, it parks in ERROR.
//   - After a halt reaches execute, it drains stages 4-5 for two cycles and
//     then parks in HALTED.
//   - It keeps a saturating count of every stall or freeze cycle.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : hazard_stall_ctrl_if.slave, which carries all status inputs and
//         control outputs
// The stall, hold, freeze and halted outputs are Mealy outputs of the FSM.
// This allows the load-use bubble to appear with zero latency.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_ADDR_LEFT = 4,
    parameter int MAX_WAIT      = 8,
    parameter int CNT_BITS      = 16
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);

    localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALTED   = 3'd3,
        ST_ERROR    = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [WAIT_BITS-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   drain_cnt_q, drain_cnt_d;
    logic                   mem_timeout_q;
    logic [CNT_BITS-1:0]    stall_count_q;

    logic                   lu_hazard;
    logic                   mem_stall;
    logic                   r1_match;
    logic                   r2_match;
    logic                   stall_pipe_s;
    logic                   hold_s1_s;
    logic                   freeze_all_s;
    logic                   halted_s;

    // Hazard detection. Register 0 is hard-wired, so it never creates a dependency.
    assign r1_match  = bus.r1_used & (bus.r1_addr == bus.waddr_s3);
    assign r2_match  = bus.r2_used & (bus.r2_addr == bus.waddr_s3);
    assign lu_hazard = bus.sel_mem_s3 & ~bus.rw_s3
                     & (bus.waddr_s3 != {(REG_ADDR_LEFT+1){1'b0}})
                     & (r1_match | r2_match);
    assign mem_stall = bus.mem_req_s4 & ~bus.mem_ready;

    // Next-state and Mealy output logic
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        stall_pipe_s = 1'b0;
        hold_s1_s    = 1'b0;
        freeze_all_s = 1'b0;
        halted_s     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    freeze_all_s = 1'b1;
                    hold_s1_s    = 1'b1;
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = WAIT_BITS'(1);
                end else if (bus.halt_s3) begin
                    // The halt itself advances into stage 4. Draining starts next cycle.
                    state_d      = ST_DRAIN;
                    drain_cnt_d  = 1'b0;
                end else if (lu_hazard) begin
                    stall_pipe_s = 1'b1;
                    hold_s1_s    = 1'b1;
                end else begin
                    state_d      = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                freeze_all_s = 1'b1;
                hold_s1_s    = 1'b1;
                if (bus.mem_ready) begin
                    // A completion on the last tolerated cycle still recovers.
                    state_d    = ST_RUN;
                    wait_cnt_d = {WAIT_BITS{1'b0}};
                end else if (wait_cnt_q == WAIT_BITS'(MAX_WAIT)) begin
                    state_d    = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
                end
            end
            ST_DRAIN: begin
                hold_s1_s = 1'b1;
                if (mem_stall) begin
                    // Freezing takes precedence: ID/EX holds, and the drain count waits.
                    freeze_all_s = 1'b1;
                end else if (drain_cnt_q) begin
                    stall_pipe_s = 1'b1;
                    state_d      = ST_HALTED;
                    drain_cnt_d  = 1'b0;
                end else begin
                    stall_pipe_s = 1'b1;
                    drain_cnt_d  = 1'b1;
                end
            end
            ST_HALTED: begin
                stall_pipe_s = 1'b1;
                hold_s1_s    = 1'b1;
                halted_s     = 1'b1;
            end
            ST_ERROR: begin
                freeze_all_s = 1'b1;
                hold_s1_s    = 1'b1;
            end
            default: begin
                state_d     = ST_RUN;
                wait_cnt_d  = {WAIT_BITS{1'b0}};
                drain_cnt_d = 1'b0;
            end
        endcase
    end

    // State, counters, sticky timeout flag and the saturating statistics counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= {WAIT_BITS{1'b0}};
            drain_cnt_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= {CNT_BITS{1'b0}};
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            mem_timeout_q <= (state_d == ST_ERROR);
            if ((stall_pipe_s | freeze_all_s) && (stall_count_q != {CNT_BITS{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_BITS'(1);
            end else begin
                stall_count_q <= stall_count_q;
            end
        end
    end

    assign bus.stall_pipe  = stall_pipe_s;
    assign bus.hold_s1     = hold_s1_s;
    assign bus.freeze_all  = freeze_all_s;
    assign bus.halted      = halted_s;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// This is a directed testbench for hazard_stall_ctrl. The bench drives the
// inputs 1 time unit after each rising edge. Before the bench samples the
// outputs on the falling edge, it pushes the expected outputs for that cycle
// onto a scoreboard queue. The expected stall_count is a saturating tally
// that the bench keeps from its own expected stall and freeze values.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int RAL = 4;
    localparam int CB  = 16;

    logic clk;
    logic rst;

    typedef struct {
        logic          stall;
        logic          hold;
        logic          freeze;
        logic          halted;
        logic          timeout;
        logic [CB-1:0] count;
    } exp_t;

    exp_t    sb_q[$];
    int      checks;
    int      errors;
    logic [CB-1:0] exp_cnt;

    hazard_stall_ctrl_if #(.REG_ADDR_LEFT(RAL), .CNT_BITS(CB)) bus ();

    hazard_stall_ctrl #(
        .REG_ADDR_LEFT(RAL),
        .MAX_WAIT     (8),
        .CNT_BITS     (CB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.r1_addr    = 5'd0;
        bus.r2_addr    = 5'd0;
        bus.r1_used    = 1'b0;
        bus.r2_used    = 1'b0;
        bus.waddr_s3   = 5'd0;
        bus.rw_s3      = 1'b1;
        bus.sel_mem_s3 = 1'b0;
        bus.halt_s3    = 1'b0;
        bus.mem_req_s4 = 1'b0;
        bus.mem_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic cmp(input string tag, input string sig, input logic [CB-1:0] got,
                       input logic [CB-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got %0h expected %0h", tag, sig, got, exp);
        end
    endtask

    // This task checks one cycle. It pushes the expectation, samples on the
    // falling edge, and then advances to just past the next rising edge.
    task automatic check(input string tag, input logic e_st, input logic e_ho,
                         input logic e_fr, input logic e_ha, input logic e_to);
        exp_t e;
        exp_t g;
        e.stall   = e_st;
        e.hold    = e_ho;
        e.freeze  = e_fr;
        e.halted  = e_ha;
        e.timeout = e_to;
        e.count   = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        cmp(tag, "stall_pipe",  {15'd0, bus.stall_pipe},  {15'd0, g.stall});
        cmp(tag, "hold_s1",     {15'd0, bus.hold_s1},     {15'd0, g.hold});
        cmp(tag, "freeze_all",  {15'd0, bus.freeze_all},  {15'd0, g.freeze});
        cmp(tag, "halted",      {15'd0, bus.halted},      {15'd0, g.halted});
        cmp(tag, "mem_timeout", {15'd0, bus.mem_timeout}, {15'd0, g.timeout});
        cmp(tag, "stall_count", bus.stall_count,          g.count);
        if ((e_st | e_fr) && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = 16'd0;
        rst     = 1'b1;
        clear_inputs();
        #1;
        do_reset();
        check("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use hazard on r2. The bubble lasts one cycle.
        bus.sel_mem_s3 = 1'b1; bus.rw_s3 = 1'b0; bus.waddr_s3 = 5'd5;
        bus.r2_used = 1'b1; bus.r2_addr = 5'd5;
        check("lu_r2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.sel_mem_s3 = 1'b0;
        check("lu_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("lu_count", "stall_count", bus.stall_count, 16'd1);

        // Hazard suppression cases
        bus.sel_mem_s3 = 1'b1; bus.waddr_s3 = 5'd0; bus.r2_addr = 5'd0;
        check("sup_r0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.waddr_s3 = 5'd5; bus.r2_addr = 5'd5; bus.rw_s3 = 1'b1;
        check("sup_nowr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.rw_s3 = 1'b0; bus.r2_used = 1'b0; bus.r1_addr = 5'd5; bus.r1_used = 1'b0;
        check("sup_unused", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.r1_used = 1'b1;
        check("lu_r1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.r1_addr = 5'd6;
        check("sup_diff", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // This test waits three cycles for memory, with a load-use hazard in the first cycle.
        clear_inputs();
        do_reset();
        bus.sel_mem_s3 = 1'b1; bus.rw_s3 = 1'b0; bus.waddr_s3 = 5'd3;
        bus.r1_used = 1'b1; bus.r1_addr = 5'd3;
        bus.mem_req_s4 = 1'b1; bus.mem_ready = 1'b0;
        check("mw_both", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.sel_mem_s3 = 1'b0;
        check("mw_1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mw_2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        check("mw_ready", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mem_req_s4 = 1'b0;
        check("mw_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp("mw_count", "stall_count", bus.stall_count, 16'd4);

        // Timeout: 9 frozen cycles (the stall cycle plus wait counts 1..8), then ERROR
        clear_inputs();
        do_reset();
        bus.mem_req_s4 = 1'b1;
        for (int i = 0; i < 9; i++) check("to_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("to_error", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.mem_ready = 1'b1;
        check("to_late_ready", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.mem_req_s4 = 1'b0;
        check("to_sticky", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        check("to_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ready on the last tolerated wait cycle recovers to RUN.
        bus.mem_req_s4 = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) check("edge_wait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mem_ready = 1'b1;
        check("edge_ready", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mem_req_s4 = 1'b0;
        check("edge_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of MEM_WAIT
        bus.mem_req_s4 = 1'b1; bus.mem_ready = 1'b0;
        check("mid_wait0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mid_wait1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mem_req_s4 = 1'b0;
        do_reset();
        check("mid_wait_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Halt: two drain cycles, then parked. Other inputs are ignored while parked.
        bus.halt_s3 = 1'b1;
        check("halt_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.halt_s3 = 1'b0;
        check("drain0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("drain1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("halted", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.sel_mem_s3 = 1'b1; bus.rw_s3 = 1'b0; bus.waddr_s3 = 5'd7;
        bus.r2_used = 1'b1; bus.r2_addr = 5'd7;
        bus.mem_req_s4 = 1'b1; bus.mem_ready = 1'b0;
        check("halted_ign", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("halted_ign2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        clear_inputs();
        do_reset();
        check("halt_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // A memory stall during DRAIN freezes the pipe, and the drain count does not advance.
        bus.halt_s3 = 1'b1;
        check("hd_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.halt_s3 = 1'b0; bus.mem_req_s4 = 1'b1;
        check("hd_frz", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.mem_req_s4 = 1'b0;
        check("hd_drain0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hd_drain1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hd_halted", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of DRAIN
        do_reset();
        bus.halt_s3 = 1'b1;
        check("md_issue", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.halt_s3 = 1'b0;
        check("md_drain0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("md_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("md_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation: hold the pipe in ERROR long enough to wrap a 16-bit counter.
        do_reset();
        bus.mem_req_s4 = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        #1;
        check("sat", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cmp("sat_val", "stall_count", bus.stall_count, 16'hFFFF);
        check("sat_hold", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
